bus_xbar: RTL and testbench

- Parametrised native-bus (valid/ready/addr/wdata/wstrb/rdata) interconnect. Replaces the fixed single-master decode/mux at SoC top.
- Arbitrates NUM_MASTERS requesters (CPU, DMA, ...) round-robin onto one shared slave bus, and decodes NUM_SLAVES base/mask windows.
- Adds a per-transaction timeout, decode-miss error responses, and an internal error-status register window with an interrupt.

---
 rtl/bus_xbar_if.sv | 37 +++
 rtl/bus_xbar.sv | 227 ++++++++++++++++++++++
 tb/tb_bus_xbar.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_xbar_if.sv
// Native-bus bundle between the requesting masters, the crossbar and the
// slave devices. Everything except clock and reset travels in here.
//   m_valid/m_addr/m_wdata/m_wstrb : per-master request (flattened vectors)
//   m_ready/m_rdata                : per-master completion pulse and read data
//   s_valid/s_addr/s_wdata/s_wstrb : one-hot slave select plus shared request
//   s_ready/s_rdata                : per-slave response
//   err_irq                        : level error interrupt
// Modport 'master' is the crossbar's view; it masters the shared slave bus.
// Modport 'slave' is the environment's view (requesters and slave devices).
interface bus_xbar_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 8
);
    logic [NUM_MASTERS-1:0]    m_valid;
    logic [32*NUM_MASTERS-1:0] m_addr;
    logic [32*NUM_MASTERS-1:0] m_wdata;
    logic [4*NUM_MASTERS-1:0]  m_wstrb;
    logic [NUM_MASTERS-1:0]    m_ready;
    logic [32*NUM_MASTERS-1:0] m_rdata;
    logic [NUM_SLAVES-1:0]     s_valid;
    logic [31:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [3:0]                s_wstrb;
    logic [NUM_SLAVES-1:0]     s_ready;
    logic [32*NUM_SLAVES-1:0]  s_rdata;
    logic                      err_irq;

    modport master (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq
    );

    modport slave (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq
    );
endinterface

// File: rtl/bus_xbar.sv
// Round-robin native-bus crossbar: NUM_MASTERS requesters share one slave
// bus decoded into NUM_SLAVES base/mask windows. Decode misses and slave
// timeouts return ERR_RDATA and are logged in a 16-byte status window at
// STAT_ADDR (+0 err_addr, +4 err_count, +8 err_irq, +C zero); any write to
// +4 clears the count and the interrupt.
// Ports: clk, reset (synchronous, active high), bus (bus_xbar_if.master).
module bus_xbar #(
    parameter int                       NUM_MASTERS    = 2,
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0000_0000}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFF00_0000}},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              STAT_ADDR      = 32'h4000_F000,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic       clk,
    input  logic       reset,
    bus_xbar_if.master bus
);
    localparam int          MW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int          SW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    // ST_TMO is the single error-response cycle that follows the last
    // unanswered BUSY cycle, so s_valid stays up for exactly TIMEOUT_CYCLES.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TMO  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     timer_q, timer_d;
    logic [31:0]     err_addr_q, err_addr_d;
    logic [15:0]     err_count_q, err_count_d;
    logic            err_irq_q, err_irq_d;

    logic [31:0]     m_addr_a  [NUM_MASTERS];
    logic [31:0]     m_wdata_a [NUM_MASTERS];
    logic [3:0]      m_wstrb_a [NUM_MASTERS];
    logic [31:0]     s_rdata_a [NUM_SLAVES];

    logic            req_valid_s;
    logic [31:0]     req_addr_s;
    logic [31:0]     req_wdata_s;
    logic [3:0]      req_wstrb_s;
    logic            stat_hit_s;
    logic [31:0]     stat_rdata_s;
    logic [NUM_SLAVES-1:0] hit_vec_s;
    logic            slv_hit_s;
    logic [SW-1:0]   slv_idx_s;
    logic [MW-1:0]   arb_idx_s;
    logic [MW-1:0]   arb_cand_s;
    logic            arb_found_s;
    logic            arb_take_s;
    logic [NUM_SLAVES-1:0] s_valid_s;
    logic            done_s;
    logic [31:0]     resp_rdata_s;
    logic            log_s;
    logic            clear_s;
    logic            busy_s;
    logic            resp_en_s;

    // Outputs are held at zero while reset is asserted, so a transfer caught
    // by reset never sees a completion pulse.
    assign busy_s    = (state_q == ST_BUSY) && !reset;
    assign resp_en_s = done_s && !reset;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
        assign m_addr_a[gi]  = bus.m_addr[32*gi +: 32];
        assign m_wdata_a[gi] = bus.m_wdata[32*gi +: 32];
        assign m_wstrb_a[gi] = bus.m_wstrb[4*gi +: 4];
        assign bus.m_ready[gi]          = resp_en_s && (grant_q == MW'(gi));
        assign bus.m_rdata[32*gi +: 32] = (resp_en_s && (grant_q == MW'(gi))) ? resp_rdata_s : 32'h0000_0000;
    end

    for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_slv
        assign s_rdata_a[gs] = bus.s_rdata[32*gs +: 32];
        assign hit_vec_s[gs] = ((req_addr_s & SLAVE_MASK[32*gs +: 32]) == SLAVE_BASE[32*gs +: 32]);
    end

    assign bus.s_valid = busy_s ? s_valid_s : {NUM_SLAVES{1'b0}};
    assign bus.s_addr  = busy_s ? req_addr_s : 32'h0000_0000;
    assign bus.s_wdata = busy_s ? req_wdata_s : 32'h0000_0000;
    assign bus.s_wstrb = busy_s ? req_wstrb_s : 4'h0;
    assign bus.err_irq = err_irq_q;

    // Granted-master mux, address decode and status-window read data.
    always_comb begin
        req_valid_s = bus.m_valid[grant_q];
        req_addr_s  = m_addr_a[grant_q];
        req_wdata_s = m_wdata_a[grant_q];
        req_wstrb_s = m_wstrb_a[grant_q];
        stat_hit_s  = ((req_addr_s & 32'hFFFF_FFF0) == STAT_ADDR);
        slv_hit_s   = |hit_vec_s;
        // Walking downwards leaves the lowest-index hit in slv_idx_s.
        slv_idx_s   = {SW{1'b0}};
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            slv_idx_s = hit_vec_s[k] ? SW'(k) : slv_idx_s;
        end
        case (req_addr_s[3:2])
            2'd0:    stat_rdata_s = err_addr_q;
            2'd1:    stat_rdata_s = {16'h0000, err_count_q};
            2'd2:    stat_rdata_s = {31'h0000_0000, err_irq_q};
            default: stat_rdata_s = 32'h0000_0000;
        endcase
    end

    // Round-robin pick: first requester at or after last_grant+1, wrapping.
    always_comb begin
        arb_idx_s   = last_grant_q;
        arb_found_s = 1'b0;
        arb_cand_s  = last_grant_q;
        arb_take_s  = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            arb_cand_s  = MW'((int'(last_grant_q) + i) % NUM_MASTERS);
            arb_take_s  = !arb_found_s && bus.m_valid[arb_cand_s];
            arb_idx_s   = arb_take_s ? arb_cand_s : arb_idx_s;
            arb_found_s = arb_found_s | arb_take_s;
        end
    end

    // Transaction FSM next state, responses and error log updates.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        err_addr_d   = err_addr_q;
        err_count_d  = err_count_q;
        err_irq_d    = err_irq_q;
        s_valid_s    = {NUM_SLAVES{1'b0}};
        done_s       = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        log_s        = 1'b0;
        clear_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.m_valid) begin
                    grant_d = arb_idx_s;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req_valid_s) begin
                    // Master withdrew: silent abort, still counts as its turn.
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else if (stat_hit_s) begin
                    done_s       = 1'b1;
                    resp_rdata_s = stat_rdata_s;
                    clear_s      = (req_wstrb_s != 4'h0) && (req_addr_s[3:2] == 2'd1);
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else if (slv_hit_s) begin
                    s_valid_s[slv_idx_s] = 1'b1;
                    if (bus.s_ready[slv_idx_s]) begin
                        done_s       = 1'b1;
                        resp_rdata_s = s_rdata_a[slv_idx_s];
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end else begin
                        timer_d = timer_q + 32'h0000_0001;
                        state_d = (timer_q == TMO_LAST) ? ST_TMO : ST_BUSY;
                    end
                end else begin
                    done_s       = 1'b1;
                    resp_rdata_s = ERR_RDATA;
                    log_s        = 1'b1;
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            ST_TMO: begin
                if (req_valid_s) begin
                    done_s       = 1'b1;
                    resp_rdata_s = ERR_RDATA;
                    log_s        = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A logged error takes precedence over a simultaneous clear.
        if (log_s) begin
            err_addr_d  = req_addr_s;
            err_count_d = (err_count_q == 16'hFFFF) ? 16'hFFFF : err_count_q + 16'h0001;
            err_irq_d   = 1'b1;
        end else if (clear_s) begin
            err_count_d = 16'h0000;
            err_irq_d   = 1'b0;
        end else begin
            err_irq_d = err_irq_q;
        end
        timer_d = (state_d == ST_IDLE) ? 32'h0000_0000 : timer_d;
    end

    // State and error-log registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= {MW{1'b0}};
            last_grant_q <= MW'(NUM_MASTERS - 1);
            timer_q      <= 32'h0000_0000;
            err_addr_q   <= 32'h0000_0000;
            err_count_q  <= 16'h0000;
            err_irq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
            err_irq_q    <= err_irq_d;
        end
    end
endmodule

// File: tb/tb_bus_xbar.sv
module tb_bus_xbar;
    localparam int NM = 2;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    int          svcnt;
    int          n_done;
    int          n_both;
    int          idx;
    logic [31:0] rd;
    logic [3:0]  sv;

    bus_xbar_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bif ();

    bus_xbar #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES(NS),
        .SLAVE_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK({4{32'hF000_0000}}),
        .TIMEOUT_CYCLES(4),
        .STAT_ADDR(32'h4000_F000),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 later.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int lat_o, output int svcnt_o,
                        output logic [31:0] rdata_o, output logic [3:0] sv_o);
        bif.m_addr[32*m +: 32]  = addr;
        bif.m_wdata[32*m +: 32] = wdata;
        bif.m_wstrb[4*m +: 4]   = strb;
        bif.m_valid[m]          = 1'b1;
        lat_o   = 0;
        svcnt_o = 0;
        rdata_o = 32'h0;
        sv_o    = 4'h0;
        #1;
        while (bif.m_ready[m] !== 1'b1 && lat_o < 20) begin
            if (bif.s_valid != 4'h0) svcnt_o++;
            @(posedge clk);
            #2;
            lat_o++;
        end
        if (bif.s_valid != 4'h0) svcnt_o++;
        if (bif.m_ready[m] === 1'b1) begin
            rdata_o = bif.m_rdata[32*m +: 32];
            sv_o    = bif.s_valid;
        end
        to_drive();
        bif.m_valid[m] = 1'b0;
    endtask

    task automatic stat_rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
        int          l;
        int          c;
        logic [31:0] r;
        logic [3:0]  v;
        xfer(0, 32'h4000_F000 | {28'h0, off}, 32'h0, 4'h0, l, c, r, v);
        check_eq(tag, r, exp);
    endtask

    initial begin
        reset       = 1'b1;
        bif.m_valid = 2'b00;
        bif.m_addr  = 64'h0;
        bif.m_wdata = 64'h0;
        bif.m_wstrb = 8'h0;
        bif.s_ready = 4'h0;
        bif.s_rdata = 128'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_m_ready", {30'h0, bif.m_ready}, 32'h0);
        check_eq("rst_s_valid", {28'h0, bif.s_valid}, 32'h0);
        check_eq("rst_s_addr", bif.s_addr, 32'h0);
        check_eq("rst_irq", {31'h0, bif.err_irq}, 32'h0);
        to_drive();

        // M0 read from slave 2, zero-wait.
        bif.s_ready = 4'b0100;
        bif.s_rdata = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
        xfer(0, 32'h2000_0010, 32'h0, 4'h0, lat, svcnt, rd, sv);
        check_eq("rd_latency", lat, 32'd1);
        check_eq("rd_rdata", rd, 32'h1234_5678);
        check_eq("rd_s_valid", {28'h0, sv}, 32'h4);
        check_eq("rd_sv_cycles", svcnt, 32'd1);
        #1;
        check_eq("rd_no_irq", {31'h0, bif.err_irq}, 32'h0);
        to_drive();

        // M1 write to an unmapped address.
        xfer(1, 32'h5000_0000, 32'hCAFE_0001, 4'hF, lat, svcnt, rd, sv);
        check_eq("miss_latency", lat, 32'd1);
        check_eq("miss_rdata", rd, 32'hDEAD_BEEF);
        check_eq("miss_s_valid", {28'h0, sv}, 32'h0);
        #1;
        check_eq("miss_irq", {31'h0, bif.err_irq}, 32'h1);
        to_drive();

        // Both masters request continuously; last grant was M1, so M0 goes first.
        bif.s_ready = 4'b1111;
        bif.s_rdata = {32'h3333_3333, 32'h0, 32'h1111_1111, 32'h0};
        bif.m_addr  = {32'h3000_0000, 32'h1000_0000};
        bif.m_wstrb = 8'h00;
        bif.m_valid = 2'b11;
        n_done = 0;
        n_both = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bif.m_ready == 2'b11) begin
                n_both++;
            end else if (bif.m_ready != 2'b00) begin
                idx = bif.m_ready[1] ? 1 : 0;
                check_eq($sformatf("rr_grant%0d", n_done), idx, n_done % 2);
                check_eq("rr_rdata", idx ? bif.m_rdata[63:32] : bif.m_rdata[31:0],
                         idx ? 32'h3333_3333 : 32'h1111_1111);
                check_eq("rr_other_rdata", idx ? bif.m_rdata[31:0] : bif.m_rdata[63:32], 32'h0);
                n_done++;
            end
            to_drive();
        end
        bif.m_valid = 2'b00;
        check_eq("rr_done", n_done, 32'd8);
        check_eq("rr_both", n_both, 32'd0);

        // Status window after the decode miss.
        stat_rd(4'h0, 32'h5000_0000, "stat_err_addr");
        stat_rd(4'h4, 32'h1, "stat_count1");
        stat_rd(4'h8, 32'h1, "stat_irq1");
        stat_rd(4'hC, 32'h0, "stat_rsvd");

        // Slave 0 never answers: four s_valid cycles, then an error response.
        bif.s_ready = 4'b1110;
        xfer(0, 32'h0000_0100, 32'h0, 4'h0, lat, svcnt, rd, sv);
        check_eq("tmo_sv_cycles", svcnt, 32'd4);
        check_eq("tmo_latency", lat, 32'd5);
        check_eq("tmo_rdata", rd, 32'hDEAD_BEEF);
        check_eq("tmo_s_valid", {28'h0, sv}, 32'h0);
        stat_rd(4'h4, 32'h2, "tmo_count2");
        stat_rd(4'h0, 32'h0000_0100, "tmo_err_addr");

        // Clear through +4, ignored write to +0, then a fresh timeout.
        xfer(1, 32'h4000_F004, 32'h0, 4'hF, lat, svcnt, rd, sv);
        check_eq("clr_latency", lat, 32'd1);
        #1;
        check_eq("clr_irq_pin", {31'h0, bif.err_irq}, 32'h0);
        to_drive();
        stat_rd(4'h4, 32'h0, "clr_count");
        stat_rd(4'h8, 32'h0, "clr_irq");
        xfer(1, 32'h4000_F000, 32'hFFFF_FFFF, 4'hF, lat, svcnt, rd, sv);
        stat_rd(4'h0, 32'h0000_0100, "wr_addr_ignored");
        xfer(0, 32'h0000_0100, 32'h0, 4'h0, lat, svcnt, rd, sv);
        check_eq("tmo2_rdata", rd, 32'hDEAD_BEEF);
        stat_rd(4'h4, 32'h1, "tmo2_count");
        stat_rd(4'h8, 32'h1, "tmo2_irq");

        // M0 withdraws while waiting on slave 0.
        bif.m_addr[31:0] = 32'h0000_0200;
        bif.m_wstrb      = 8'h00;
        bif.m_valid      = 2'b01;
        to_drive();
        #1;
        check_eq("abort_sv_busy", {28'h0, bif.s_valid}, 32'h1);
        to_drive();
        bif.m_valid = 2'b00;
        #1;
        check_eq("abort_sv_drop", {28'h0, bif.s_valid}, 32'h0);
        check_eq("abort_no_ready", {30'h0, bif.m_ready}, 32'h0);
        to_drive();
        // Abort counted as M0's turn, so M1 must win the next contest.
        bif.s_ready = 4'b1111;
        bif.m_addr  = {32'h3000_0000, 32'h2000_0000};
        bif.m_valid = 2'b11;
        #1;
        check_eq("abort_idle", {28'h0, bif.s_valid}, 32'h0);
        to_drive();
        #1;
        check_eq("abort_next_grant", {30'h0, bif.m_ready}, 32'h2);
        check_eq("abort_next_rdata", bif.m_rdata[63:32], 32'h3333_3333);
        to_drive();
        bif.m_valid = 2'b00;

        // Reset while M0 waits on slave 0; the slave answers during reset.
        bif.s_ready      = 4'b1110;
        bif.s_rdata      = {32'h3333_3333, 32'h0, 32'h0, 32'hA0A0_0000};
        bif.m_addr[31:0] = 32'h0000_0300;
        bif.m_valid      = 2'b01;
        to_drive();
        reset       = 1'b1;
        bif.s_ready = 4'b1111;
        #1;
        check_eq("rst_busy_no_ready", {30'h0, bif.m_ready}, 32'h0);
        to_drive();
        reset = 1'b0;
        #1;
        check_eq("rst_busy_idle", {28'h0, bif.s_valid}, 32'h0);
        check_eq("rst_busy_ready0", {30'h0, bif.m_ready}, 32'h0);
        check_eq("rst_busy_irq", {31'h0, bif.err_irq}, 32'h0);
        to_drive();
        #1;
        check_eq("rst_fresh_ready", {30'h0, bif.m_ready}, 32'h1);
        check_eq("rst_fresh_rdata", bif.m_rdata[31:0], 32'hA0A0_0000);
        to_drive();
        bif.m_valid = 2'b00;
        stat_rd(4'h4, 32'h0, "rst_count");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
